// File: rtl/ram_dual_port.sv
// Dual-port RAM: port A read/write, port B read-only, with a post-reset zero-fill sequencer.
// Latency: 1 active edge on both read ports. Writes take effect at that edge.
// Backpressure: none. Requests made while busy is high are dropped, not stalled.
`ifndef POS_EDGE
`define POS_EDGE 1
`endif

module ram_dual_port #(
    parameter int addr_width     = 8,
    parameter int data_width     = 8,
    parameter int active_edge    = `POS_EDGE,
    parameter int rdw_mode       = 0,
    parameter int clear_on_reset = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_din,
    output logic [data_width-1:0] a_dout,
    input  logic                  b_en,
    input  logic [addr_width-1:0] b_addr,
    output logic [data_width-1:0] b_dout,
    output logic                  busy
);
    localparam int depth = 1 << addr_width;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [addr_width-1:0] cnt;
    logic [data_width-1:0] mem [depth];
    logic                  local_clk;
    logic                  cnt_last;
    logic                  a_wr;
    logic                  collide;

    // Falling-edge operation is a plain clock inversion; everything below is posedge local_clk.
    assign local_clk = (active_edge == `POS_EDGE) ? clk : ~clk;

    assign cnt_last = (cnt == {addr_width{1'b1}});
    assign a_wr     = a_en && a_we && (state == IDLE);
    assign collide  = a_wr && b_en && (b_addr == a_addr);
    assign busy     = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        if (rst) begin
            state_nxt = (clear_on_reset != 0) ? CLEAR : IDLE;
        end else if (state == CLEAR && cnt_last) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge local_clk) begin
        state <= state_nxt;
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge local_clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (a_wr) begin
                mem[a_addr] <= a_din;
            end
        end
    end

    // Reads see the pre-edge array; write-first forwarding is explicit from a_din.
    always_ff @(posedge local_clk) begin
        if (rst || state == CLEAR) begin
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            if (a_en) begin
                a_dout <= (a_we && rdw_mode != 0) ? a_din : mem[a_addr];
            end
            if (b_en) begin
                b_dout <= (collide && rdw_mode != 0) ? a_din : mem[b_addr];
            end
        end
    end
endmodule

// File: tb/tb_ram_dual_port.sv
// Randomized bench for ram_dual_port: three configurations share one stimulus stream and a behavioural model.
module tb_ram_dual_port;
    localparam int N     = 3;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_en = 1'b0;
    logic          a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [7:0]    a_din = '0;
    logic          b_en = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [7:0]    a_dout_w [N];
    logic [7:0]    b_dout_w [N];
    logic          busy_w   [N];

    int checks = 0;
    int errors = 0;

    // inst0: read-first + clear, inst1: write-first + clear, inst2: read-first, no clear
    int rdw_p [N] = '{0, 1, 0};
    int clr_p [N] = '{1, 1, 0};

    logic [7:0] m_mem   [N][DEPTH];
    bit         m_known [N][DEPTH];
    bit         m_busy  [N];
    int         m_cnt   [N];
    logic [7:0] m_a     [N];
    logic [7:0] m_b     [N];
    bit         m_ak    [N];
    bit         m_bk    [N];

    always #5 clk = ~clk;

    ram_dual_port #(.addr_width(AW), .data_width(8), .rdw_mode(0), .clear_on_reset(1)) u0 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout_w[0]), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout_w[0]), .busy(busy_w[0]));
    ram_dual_port #(.addr_width(AW), .data_width(8), .rdw_mode(1), .clear_on_reset(1)) u1 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout_w[1]), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout_w[1]), .busy(busy_w[1]));
    ram_dual_port #(.addr_width(AW), .data_width(8), .rdw_mode(0), .clear_on_reset(0)) u2 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout_w[2]), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout_w[2]), .busy(busy_w[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // What one active edge must do, given the inputs currently driven.
    task automatic model_step();
        logic [7:0] old_a;
        logic [7:0] old_b;
        bit         k_a;
        bit         k_b;
        bit         wr;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_busy[i] = (clr_p[i] != 0);
                m_cnt[i]  = 0;
                m_a[i] = 8'h00; m_b[i] = 8'h00; m_ak[i] = 1; m_bk[i] = 1;
            end else if (m_busy[i]) begin
                m_mem[i][m_cnt[i]]   = 8'h00;
                m_known[i][m_cnt[i]] = 1;
                m_cnt[i]++;
                if (m_cnt[i] == DEPTH) m_busy[i] = 0;
                m_a[i] = 8'h00; m_b[i] = 8'h00; m_ak[i] = 1; m_bk[i] = 1;
            end else begin
                old_a = m_mem[i][a_addr]; k_a = m_known[i][a_addr];
                old_b = m_mem[i][b_addr]; k_b = m_known[i][b_addr];
                wr = a_en && a_we;
                if (a_en) begin
                    if (wr && rdw_p[i] != 0) begin
                        m_a[i] = a_din; m_ak[i] = 1;
                    end else begin
                        m_a[i] = old_a; m_ak[i] = k_a;
                    end
                end
                if (b_en) begin
                    if (wr && b_addr == a_addr && rdw_p[i] != 0) begin
                        m_b[i] = a_din; m_bk[i] = 1;
                    end else begin
                        m_b[i] = old_b; m_bk[i] = k_b;
                    end
                end
                if (wr) begin
                    m_mem[i][a_addr] = a_din; m_known[i][a_addr] = 1;
                end
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < N; i++) begin
            check($sformatf("inst%0d busy", i), {31'b0, busy_w[i]}, {31'b0, m_busy[i]});
            if (m_ak[i]) check($sformatf("inst%0d a_dout", i), {24'b0, a_dout_w[i]}, {24'b0, m_a[i]});
            if (m_bk[i]) check($sformatf("inst%0d b_dout", i), {24'b0, b_dout_w[i]}, {24'b0, m_b[i]});
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive(input bit r, input bit ae, input bit we, input int aa,
                         input int din, input bit be, input int ba);
        rst = r; a_en = ae; a_we = we; a_addr = AW'(aa); a_din = 8'(din); b_en = be; b_addr = AW'(ba);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_cnt[i] = 0; m_ak[i] = 0; m_bk[i] = 0;
            m_a[i] = 8'h00; m_b[i] = 8'h00;
            for (int k = 0; k < DEPTH; k++) begin
                m_known[i][k] = 0; m_mem[i][k] = 8'h00;
            end
        end

        // Initial reset and clear, then preload mem[5]=A5.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) tick();
        drive(0, 1, 1, 5, 8'hA5, 0, 0);
        tick();
        drive(0, 1, 0, 5, 0, 1, 5);
        tick();
        check("preload a", {24'b0, a_dout_w[0]}, 32'hA5);

        // Three reset cycles with write attempts that must be ignored.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, k, 8'hFF, 1, k);
            tick();
        end
        check("rst busy clr", {31'b0, busy_w[0]}, 32'd1);
        check("rst busy noclr", {31'b0, busy_w[2]}, 32'd0);
        check("rst a_dout", {24'b0, a_dout_w[0]}, 32'h0);
        check("rst b_dout", {24'b0, b_dout_w[1]}, 32'h0);

        // Full clear with dropped 0xFF writes on the clearing instances.
        for (int k = 1; k <= DEPTH; k++) begin
            drive(0, 1, 1, $urandom_range(0, DEPTH - 1), 8'hFF, 1, $urandom_range(0, DEPTH - 1));
            tick();
            if (k == DEPTH - 1) check("busy before last clear", {31'b0, busy_w[0]}, 32'd1);
            if (k == DEPTH)     check("busy after clear", {31'b0, busy_w[0]}, 32'd0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 1, 0, k, 0, 1, DEPTH - 1 - k);
            tick();
            if (k == 5) check("cleared mem5", {24'b0, a_dout_w[0]}, 32'h0);
        end

        // Basic write then read on both ports, then hold.
        drive(0, 1, 1, 16, 8'h3C, 0, 0);
        tick();
        drive(0, 1, 0, 16, 0, 1, 16);
        tick();
        check("rw a", {24'b0, a_dout_w[0]}, 32'h3C);
        check("rw b", {24'b0, b_dout_w[0]}, 32'h3C);
        drive(0, 0, 0, 1, 0, 0, 2);
        tick();
        tick();
        check("hold a", {24'b0, a_dout_w[0]}, 32'h3C);
        check("hold b", {24'b0, b_dout_w[1]}, 32'h3C);

        // Same-address collision under both read-during-write policies.
        drive(0, 1, 1, 7, 8'h11, 0, 0);
        tick();
        drive(0, 1, 1, 7, 8'h22, 1, 7);
        tick();
        check("rdw0 a", {24'b0, a_dout_w[0]}, 32'h11);
        check("rdw0 b", {24'b0, b_dout_w[0]}, 32'h11);
        check("rdw1 a", {24'b0, a_dout_w[1]}, 32'h22);
        check("rdw1 b", {24'b0, b_dout_w[1]}, 32'h22);
        drive(0, 1, 0, 7, 0, 1, 7);
        tick();
        check("after coll b", {24'b0, b_dout_w[0]}, 32'h22);

        // Reset in the middle of a clear restarts the full sequence.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 9; k++) begin
            drive(0, 1, 1, k, 8'hFF, 1, k);
            tick();
        end
        drive(1, 1, 1, 0, 8'hFF, 0, 0);
        tick();
        n = 0;
        do begin
            drive(0, 1, 1, $urandom_range(0, DEPTH - 1), 8'hFF, 1, $urandom_range(0, DEPTH - 1));
            tick();
            n++;
        end while (busy_w[0] && n < 40);
        check("midclear edges", n, DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 1, 0, k, 0, 1, k);
            tick();
            if (k == 3) check("midclear mem3", {24'b0, b_dout_w[1]}, 32'h0);
        end

        // No-clear instance keeps its contents across reset.
        drive(0, 1, 1, 3, 8'h5A, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("noclr busy", {31'b0, busy_w[2]}, 32'd0);
        check("noclr a zero", {24'b0, a_dout_w[2]}, 32'h0);
        drive(0, 1, 0, 3, 0, 1, 3);
        tick();
        check("noclr keep", {24'b0, a_dout_w[2]}, 32'h5A);
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
        end

        // Random traffic, biased to a few addresses to force collisions.
        for (int k = 0; k < 800; k++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3),
                  $urandom_range(0, 255), $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
